// File: rtl/cis_capture.sv
// Parallel CMOS image sensor capture front end: synchronizes the CIS pad
// group, frames pixels into a sof/eol-tagged stream and buffers it in a
// show-ahead FIFO with line, frame and overflow status.
module cis_capture #(
   parameter int unsigned DW         = 10,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_W      = 12
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   input  logic             enable_i,
   input  logic             cis_pclk_i,
   input  logic             cis_hsync_i,
   input  logic             cis_vsync_i,
   input  logic [DW-1:0]    cis_data_i,
   output logic [DW-1:0]    pix_data_o,
   output logic             pix_valid_o,
   input  logic             pix_ready_i,
   output logic             pix_sof_o,
   output logic             pix_eol_o,
   output logic [CNT_W-1:0] line_len_o,
   output logic [CNT_W-1:0] frame_lines_o,
   output logic [15:0]      frame_cnt_o,
   output logic             overflow_o,
   input  logic             clr_ovf_i
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned EW = DW + 2;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FRAME = 2'd1,
      ACTIVE     = 2'd2
   } state_t;

   state_t state;

   // Synchronizer stages; pclk carries a third stage for edge detection
   logic [2:0]    pclk_sync;
   logic [1:0]    hs_sync;
   logic [1:0]    vs_sync;
   logic [DW-1:0] d_s1;
   logic [DW-1:0] d_s2;

   // Event history, staging and counters
   logic             vs_prev;
   logic             hist_valid;
   logic             stg_valid;
   logic             stg_sof;
   logic [DW-1:0]    stg_data;
   logic             sof_pending;
   logic [CNT_W-1:0] pix_cnt;
   logic [CNT_W-1:0] line_cnt;

   // FIFO storage and pointers
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic          ev;
   logic          hs;
   logic          vs;
   logic          vs_rise;
   logic          vs_fall;
   logic          push;
   logic          push_eol;
   logic          line_end;
   logic          pop;
   logic          full;
   logic          wr;
   logic          drop;
   logic [EW-1:0] head;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   // Two-flop synchronizers on every sensor input
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         pclk_sync <= '0;
         hs_sync   <= '0;
         vs_sync   <= '0;
         d_s1      <= '0;
         d_s2      <= '0;
      end else begin
         pclk_sync <= {pclk_sync[1:0], cis_pclk_i};
         hs_sync   <= {hs_sync[0], cis_hsync_i};
         vs_sync   <= {vs_sync[0], cis_vsync_i};
         d_s1      <= cis_data_i;
         d_s2      <= d_s1;
      end
   end

   // PCLK rise event and vsync edges judged against the previous event
   always_comb begin
      ev      = pclk_sync[1] & ~pclk_sync[2];
      hs      = hs_sync[1];
      vs      = vs_sync[1];
      vs_rise = ev & hist_valid & vs & ~vs_prev;
      vs_fall = ev & hist_valid & ~vs & vs_prev;
   end

   // Staged pixel leaves on the next event; eol when the line or frame ends
   always_comb begin
      push     = (state == ACTIVE) && ev && stg_valid;
      push_eol = vs_fall | ~hs;
      line_end = push & push_eol;
   end

   // Capture FSM, pixel staging and line/frame counters
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state         <= IDLE;
         vs_prev       <= 1'b0;
         hist_valid    <= 1'b0;
         stg_valid     <= 1'b0;
         stg_sof       <= 1'b0;
         stg_data      <= '0;
         sof_pending   <= 1'b0;
         pix_cnt       <= '0;
         line_cnt      <= '0;
         line_len_o    <= '0;
         frame_lines_o <= '0;
         frame_cnt_o   <= '0;
      end else begin
         if (ev) begin
            vs_prev    <= vs;
            hist_valid <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (enable_i) state <= WAIT_FRAME;
            end
            WAIT_FRAME: begin
               if (!enable_i) begin
                  state <= IDLE;
               end else if (vs_rise) begin
                  state       <= ACTIVE;
                  line_cnt    <= '0;
                  pix_cnt     <= '0;
                  stg_valid   <= 1'b0;
                  sof_pending <= 1'b1;
               end
            end
            ACTIVE: begin
               if (line_end) begin
                  line_len_o <= pix_cnt;
                  pix_cnt    <= '0;
                  stg_valid  <= 1'b0;
                  line_cnt   <= sat_inc(line_cnt);
               end
               if (vs_fall) begin
                  frame_cnt_o   <= frame_cnt_o + 16'd1;
                  frame_lines_o <= line_end ? sat_inc(line_cnt) : line_cnt;
                  state         <= enable_i ? WAIT_FRAME : IDLE;
               end else if (ev && hs) begin
                  stg_valid   <= 1'b1;
                  stg_data    <= d_s2;
                  stg_sof     <= sof_pending;
                  sof_pending <= 1'b0;
                  pix_cnt     <= sat_inc(pix_cnt);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // FIFO accept/drop decision; a same-cycle pop frees a slot
   always_comb begin
      pop  = pix_valid_o & pix_ready_i;
      full = (count == (AW+1)'(FIFO_DEPTH));
      wr   = push & (~full | pop);
      drop = push & full & ~pop;
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({wr, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (drop) overflow_o <= 1'b1;
         else if (clr_ovf_i) overflow_o <= 1'b0;
      end
   end

   // FIFO storage; contents are only observed through the valid-gated head
   always_ff @(posedge wb_clk_i) begin
      if (wr) mem[wr_ptr] <= {stg_sof, push_eol, stg_data};
   end

   // Show-ahead head, forced to zero while empty
   always_comb begin
      head        = mem[rd_ptr];
      pix_valid_o = (count != '0);
      pix_data_o  = pix_valid_o ? head[DW-1:0] : '0;
      pix_eol_o   = pix_valid_o & head[DW];
      pix_sof_o   = pix_valid_o & head[DW+1];
   end

endmodule

// File: tb/tb_cis_capture.sv
// Directed bench for cis_capture: drives sensor frames at PCLK = clk/4 and
// compares the captured pixel stream and status against hand-built tables.
module tb_cis_capture;

   localparam int unsigned DW    = 10;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned CW    = 12;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          cis_pclk;
   logic          cis_hsync;
   logic          cis_vsync;
   logic [DW-1:0] cis_data;
   logic [DW-1:0] pix_data;
   logic          pix_valid;
   logic          pix_ready;
   logic          pix_sof;
   logic          pix_eol;
   logic [CW-1:0] line_len;
   logic [CW-1:0] frame_lines;
   logic [15:0]   frame_cnt;
   logic          overflow;
   logic          clr_ovf;

   always #5 clk = ~clk;

   cis_capture #(.DW(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .wb_clk_i      (clk),
      .wb_rst_ni     (rst_n),
      .enable_i      (enable),
      .cis_pclk_i    (cis_pclk),
      .cis_hsync_i   (cis_hsync),
      .cis_vsync_i   (cis_vsync),
      .cis_data_i    (cis_data),
      .pix_data_o    (pix_data),
      .pix_valid_o   (pix_valid),
      .pix_ready_i   (pix_ready),
      .pix_sof_o     (pix_sof),
      .pix_eol_o     (pix_eol),
      .line_len_o    (line_len),
      .frame_lines_o (frame_lines),
      .frame_cnt_o   (frame_cnt),
      .overflow_o    (overflow),
      .clr_ovf_i     (clr_ovf)
   );

   // One record per expected beat: the pixel sent and its expected markers
   typedef struct {
      logic [DW-1:0] pix;
      logic          sof;
      logic          eol;
   } vec_t;

   vec_t          tbl [16];
   logic [DW+1:0] beats [$];
   int            checks = 0;
   int            errors = 0;

   // Record every accepted beat as {sof, eol, data}
   always @(negedge clk) begin
      if (pix_valid && pix_ready) beats.push_back({pix_sof, pix_eol, pix_data});
   end

   task automatic wait_clk(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic put(input int i, input int pix, input logic sof, input logic eol);
      tbl[i].pix = DW'(pix);
      tbl[i].sof = sof;
      tbl[i].eol = eol;
   endtask

   task automatic check_beats(input string name, input int n);
      check($sformatf("%s_count", name), 32'(beats.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < beats.size())
            check($sformatf("%s[%0d]", name, i), 32'(beats[i]),
                  32'({tbl[i].sof, tbl[i].eol, tbl[i].pix}));
      end
   endtask

   // One PCLK period: inputs change with PCLK low, held through the rise
   task automatic pclk_cycle(input logic hs, input logic vs, input int d);
      cis_pclk  = 1'b0;
      cis_hsync = hs;
      cis_vsync = vs;
      cis_data  = DW'(d);
      wait_clk(2);
      cis_pclk = 1'b1;
      wait_clk(2);
   endtask

   task automatic start_frame();
      pclk_cycle(1'b0, 1'b1, 0);
      pclk_cycle(1'b0, 1'b1, 0);
   endtask

   task automatic send_line(input int n, input int base);
      for (int i = 0; i < n; i++) pclk_cycle(1'b1, 1'b1, base + i);
      pclk_cycle(1'b0, 1'b1, 0);
   endtask

   task automatic end_frame();
      pclk_cycle(1'b0, 1'b0, 0);
      pclk_cycle(1'b0, 1'b0, 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      enable    = 1'b0;
      pix_ready = 1'b1;
      clr_ovf   = 1'b0;
      cis_pclk  = 1'b0;
      cis_hsync = 1'b0;
      cis_vsync = 1'b0;
      cis_data  = '0;

      // Reset with random sensor activity
      repeat (3) begin
         cis_pclk  = 1'($urandom);
         cis_hsync = 1'($urandom);
         cis_vsync = 1'($urandom);
         cis_data  = DW'($urandom);
         wait_clk(1);
      end
      check("rst_valid", 32'(pix_valid), 0);
      check("rst_data", 32'(pix_data), 0);
      check("rst_sof", 32'(pix_sof), 0);
      check("rst_eol", 32'(pix_eol), 0);
      check("rst_line_len", 32'(line_len), 0);
      check("rst_frame_lines", 32'(frame_lines), 0);
      check("rst_frame_cnt", 32'(frame_cnt), 0);
      check("rst_overflow", 32'(overflow), 0);
      cis_pclk = 1'b0; cis_hsync = 1'b0; cis_vsync = 1'b0; cis_data = '0;
      rst_n = 1'b1;
      pclk_cycle(1'b0, 1'b0, 0);
      pclk_cycle(1'b0, 1'b0, 0);
      check("idle_valid", 32'(pix_valid), 0);

      // Basic frame: 2 lines x 4 pixels
      for (int i = 0; i < 8; i++) put(i, i + 1, i == 0, (i == 3) || (i == 7));
      beats.delete();
      enable = 1'b1;
      pclk_cycle(1'b0, 1'b0, 0);
      start_frame();
      send_line(4, 1);
      send_line(4, 5);
      end_frame();
      wait_clk(6);
      check_beats("basic", 8);
      check("basic_line_len", 32'(line_len), 4);
      check("basic_frame_lines", 32'(frame_lines), 2);
      check("basic_frame_cnt", 32'(frame_cnt), 1);

      // Enable raised while VSYNC is already high: that frame is skipped
      put(0, 'h20, 1'b1, 1'b0);
      put(1, 'h21, 1'b0, 1'b0);
      put(2, 'h22, 1'b0, 1'b1);
      enable = 1'b0;
      wait_clk(2);
      beats.delete();
      start_frame();
      send_line(3, 'h100);
      enable = 1'b1;
      send_line(3, 'h110);
      end_frame();
      wait_clk(4);
      check("midena_skipped", 32'(beats.size()), 0);
      check("midena_frame_cnt0", 32'(frame_cnt), 1);
      start_frame();
      send_line(3, 'h20);
      end_frame();
      wait_clk(6);
      check_beats("midena", 3);
      check("midena_frame_cnt", 32'(frame_cnt), 2);
      check("midena_frame_lines", 32'(frame_lines), 1);

      // Overflow: 12-pixel line into an 8-entry FIFO with ready low
      for (int i = 0; i < 8; i++) put(i, i + 1, i == 0, 1'b0);
      beats.delete();
      pix_ready = 1'b0;
      start_frame();
      send_line(12, 1);
      end_frame();
      wait_clk(4);
      check("ovf_valid", 32'(pix_valid), 1);
      check("ovf_flag", 32'(overflow), 1);
      check("ovf_line_len", 32'(line_len), 12);
      check("ovf_head", 32'(pix_data), 1);
      clr_ovf = 1'b1;
      wait_clk(1);
      clr_ovf = 1'b0;
      wait_clk(1);
      check("ovf_cleared", 32'(overflow), 0);
      pix_ready = 1'b1;
      wait_clk(12);
      check_beats("ovf_drain", 8);
      check("ovf_empty", 32'(pix_valid), 0);
      check("ovf_frame_cnt", 32'(frame_cnt), 3);

      // Disable during line 1 of a 3-line frame: frame still completes
      put(0, 'h30, 1'b1, 1'b0);
      put(1, 'h31, 1'b0, 1'b1);
      put(2, 'h32, 1'b0, 1'b0);
      put(3, 'h33, 1'b0, 1'b1);
      put(4, 'h34, 1'b0, 1'b0);
      put(5, 'h35, 1'b0, 1'b1);
      beats.delete();
      start_frame();
      pclk_cycle(1'b1, 1'b1, 'h30);
      enable = 1'b0;
      pclk_cycle(1'b1, 1'b1, 'h31);
      pclk_cycle(1'b0, 1'b1, 0);
      send_line(2, 'h32);
      send_line(2, 'h34);
      end_frame();
      wait_clk(6);
      check_beats("dis", 6);
      check("dis_frame_cnt", 32'(frame_cnt), 4);
      check("dis_frame_lines", 32'(frame_lines), 3);
      beats.delete();
      start_frame();
      send_line(2, 'h40);
      end_frame();
      wait_clk(6);
      check("dis_ignored", 32'(beats.size()), 0);
      check("dis_frame_cnt_hold", 32'(frame_cnt), 4);

      // Reset after two pixels of a line, then a clean frame
      enable = 1'b1;
      pclk_cycle(1'b0, 1'b0, 0);
      start_frame();
      pclk_cycle(1'b1, 1'b1, 'h50);
      pclk_cycle(1'b1, 1'b1, 'h51);
      rst_n = 1'b0;
      wait_clk(3);
      check("mrst_valid", 32'(pix_valid), 0);
      check("mrst_data", 32'(pix_data), 0);
      check("mrst_frame_cnt", 32'(frame_cnt), 0);
      check("mrst_line_len", 32'(line_len), 0);
      rst_n = 1'b1;
      beats.delete();
      pclk_cycle(1'b1, 1'b1, 'h52);
      pclk_cycle(1'b0, 1'b1, 0);
      end_frame();
      wait_clk(4);
      check("mrst_aborted", 32'(beats.size()), 0);
      for (int i = 0; i < 6; i++) put(i, 'h60 + i, i == 0, (i == 2) || (i == 5));
      start_frame();
      send_line(3, 'h60);
      send_line(3, 'h63);
      end_frame();
      wait_clk(6);
      check_beats("mrst", 6);
      check("mrst_frame_cnt1", 32'(frame_cnt), 1);
      check("mrst_frame_lines", 32'(frame_lines), 2);
      check("mrst_line_len3", 32'(line_len), 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
